// File: rtl/sha2_msg_sched_dual_if.sv
// Word-stream bundle for the SHA-2 message schedule.
// slave = schedule side, master = padder/round-core side.
interface sha2_msg_sched_dual_if #(
  parameter int ROUND_W = 7
);
  logic               in_valid;
  logic               in_ready;
  logic [63:0]        data_in;
  logic               out_valid;
  logic               out_ready;
  logic [63:0]        data_out;
  logic [ROUND_W-1:0] round;
  logic               last;

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out,
    output round, last
  );

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out,
    input  round, last
  );
endinterface

// File: rtl/sha2_msg_sched_dual.sv
// SHA-256/512 message schedule: loads 16 words, emits W[0..N-1].
// Ports: clk, rst (async low), start, mode, abort, busy, bus (slave).
// SHA2_MS_SHA512_EN enables the 64-bit / 80-round datapath.
module sha2_msg_sched_dual #(
  parameter int ROUNDS_256 = 64,
  parameter int ROUNDS_512 = 80,
  parameter int ROUND_W    = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic mode,
  input  logic abort,
  output logic busy,
  sha2_msg_sched_dual_if.slave bus
);

`ifdef SHA2_MS_SHA512_EN
  localparam int DW    = 64;
  localparam bit EN512 = 1'b1;
`else
  localparam int DW    = 32;
  localparam bit EN512 = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_EXP  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               mode_q, mode_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [DW-1:0]      mem_q [16];
  logic [DW-1:0]      din_w, nw_w;
  logic [ROUND_W-1:0] rlast_w;
  logic               ld_w, sh_w, mode_e;
  logic               is_idle, is_load, is_exp;

  function automatic logic [31:0] s0_32(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1_32(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

`ifdef SHA2_MS_SHA512_EN
  function automatic logic [63:0] s0_64(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  function automatic logic [63:0] s1_64(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  logic [31:0] w32_w;
  logic [63:0] w64_w;

  always_comb begin
    w32_w = s0_32(mem_q[1][31:0]) + s1_32(mem_q[14][31:0])
          + mem_q[0][31:0] + mem_q[9][31:0];
    w64_w = s0_64(mem_q[1]) + s1_64(mem_q[14])
          + mem_q[0] + mem_q[9];
    nw_w  = mode_e ? w64_w : {32'd0, w32_w};
    din_w = mode_e ? bus.data_in
                   : {32'd0, bus.data_in[31:0]};
  end
`else
  logic unused_hi;
  assign unused_hi = ^bus.data_in[63:32];
  assign nw_w  = s0_32(mem_q[1]) + s1_32(mem_q[14])
               + mem_q[0] + mem_q[9];
  assign din_w = bus.data_in[31:0];
`endif

  // Mode can only take effect when the wide datapath exists.
  assign mode_e  = mode_q & EN512;
  assign rlast_w = mode_e ? ROUND_W'(ROUNDS_512 - 1)
                          : ROUND_W'(ROUNDS_256 - 1);

  assign is_idle = (state_q == S_IDLE);
  assign is_load = (state_q == S_LOAD);
  assign is_exp  = (state_q == S_EXP);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    ld_w    = 1'b0;
    sh_w    = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      round_d = '0;
    end else begin
      unique case (1'b1)
        is_idle: begin
          if (start) begin
            state_d = S_LOAD;
            mode_d  = mode;
            cnt_d   = '0;
          end
        end
        is_load: begin
          if (bus.in_valid) begin
            ld_w  = 1'b1;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_d = S_EXP;
              round_d = '0;
            end
          end
        end
        is_exp: begin
          if (bus.out_ready) begin
            sh_w = 1'b1;
            if (round_q == rlast_w) begin
              state_d = S_IDLE;
              round_d = '0;
            end else begin
              round_d = round_q + ROUND_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      round_q <= '0;
      for (int i = 0; i < 16; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      if (ld_w || sh_w) begin
        for (int i = 0; i < 15; i++) mem_q[i] <= mem_q[i+1];
        mem_q[15] <= ld_w ? din_w : nw_w;
      end
    end
  end

  assign bus.in_ready  = is_load;
  assign bus.out_valid = is_exp;
  assign bus.data_out  = is_exp ? 64'(mem_q[0]) : 64'd0;
  assign bus.round     = round_q;
  assign bus.last      = is_exp && (round_q == rlast_w);
  assign busy          = !is_idle;

endmodule

// File: doc/sha2_msg_sched_dual.md
# sha2_msg_sched_dual

Runtime-selectable SHA-2 message schedule producing the word stream W[0..N-1] for one 512- or 1024-bit block. It replaces the fixed-mode, free-running schedule with one datapath serving both word sizes. Input and output use valid/ready handshakes, and an FSM tracks load and expansion. It sits between the block padder (word source) and the compression round core (word sink) in the EdDSA/SHA-2 hash path.

## Interface
- ROUNDS_256, default 64: words emitted in mode 0 (SHA-224/256).
- ROUNDS_512, default 80: words emitted in mode 1 (SHA-384/512).
- ROUND_W, default 7: round index width; must satisfy 2^ROUND_W ≥ max(ROUNDS_256, ROUNDS_512).
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset, asynchronous, active-low.
- start, in, 1: pulse; begins a block, sampled only in IDLE.
- mode, in, 1: 0 = 32-bit words / ROUNDS_256; 1 = 64-bit words / ROUNDS_512. Latched on accepted start.
- abort, in, 1: synchronous return to IDLE from any state.
- in_valid, in, 1: data_in holds a message word.
- in_ready, out, 1: block accepts a word.
- data_in, in, 64: message word, big-endian word order; mode 0 uses [31:0].
- out_valid, out, 1: data_out holds W[round].
- out_ready, in, 1: sink consumes the word.
- data_out, out, 64: schedule word; [63:32] = 0 in mode 0.
- round, out, ROUND_W: index t of the word on data_out.
- last, out, 1: out_valid && round == N-1.
- busy, out, 1: state != IDLE.

## Operation
- Storage: 16×64-bit shift register MEM[0..15]. A shift moves MEM[i] ← MEM[i+1] and writes MEM[15].
- FSM states:
  - IDLE: start moves to LOAD, latches mode, and clears the load counter.
  - LOAD: in_ready=1. Each in_valid handshake shifts and writes data_in (mode 0: zero-extended [31:0]) into MEM[15]. The 16th handshake moves to EXPAND with round=0.
  - EXPAND: out_valid=1, data_out=MEM[0]. On an out_ready handshake:
    - shift, and write MEM[15] ← σ0'(MEM[1]) + σ1'(MEM[14]) + MEM[0] + MEM[9];
    - round increments;
    - the handshake with round == N-1 moves to IDLE.
- Arithmetic:
  - mode 0: σ0 = ROTR7^ROTR18^SHR3, σ1 = ROTR17^ROTR19^SHR10 on [31:0]; sum mod 2^32; upper half written as 0.
  - mode 1: σ0 = ROTR1^ROTR8^SHR7, σ1 = ROTR19^ROTR61^SHR6; sum mod 2^64.
- The first 16 emitted words equal the loaded words in order. Expansion words computed after round N-17 are never emitted.
- Boundary rules:
  - out_ready low in EXPAND: all state and outputs hold.
  - in_valid in IDLE or EXPAND: ignored (in_ready=0).
  - start outside IDLE: ignored; mode changes outside IDLE: ignored.
  - abort (priority over start and handshakes): next state IDLE, round=0, load counter=0. MEM contents are don't-care but must not emit.
  - Asynchronous reset mid-block: identical to abort, plus MEM cleared.
- Reset values: state IDLE, MEM all 0, round 0, in_ready 0, out_valid 0, data_out 0, last 0, busy 0.

## Timing
- Accepted start at cycle c gives in_ready=1 at c+1.
- 16th input handshake at cycle d gives out_valid=1 with W[0] at d+1.
- Throughput is one word per cycle while out_ready=1. The σ/add path is combinational from MEM into MEM[15], single cycle.
- Final handshake at cycle e gives busy=0 at e+1. The next start is accepted at e+1 at the earliest.
- Minimum block period with no stalls: 1 + 16 + N cycles.
- data_out, round and last are registered or derived solely from registers. There is no combinational path from inputs to outputs except in_ready/out_valid, which depend on state only.

## Configuration
- SHA2_MS_SHA512_EN defined: full 64-bit datapath; mode honoured; ROUNDS_512 path present.
- SHA2_MS_SHA512_EN undefined:
  - MEM and adders are 32-bit; mode is treated as 0 internally; SHA-512 σ functions are not instantiated.
  - data_out[63:32] is tied 0 and port widths are unchanged.
  - Emitted length is always ROUNDS_256.

## Test plan
- SHA-256 "abc" (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1 -> W16=0x61626380, W17=0x000F0000, last at round 63, 64 words, busy=0 one cycle later.
- SHA-512 "abc" (W0=0x6162638000000000, W15=0x18), mode=1 -> W16=0x6162638000000000, W17=0x00030000000000C0, last at round 79. Without the macro -> mode ignored, 64 words emitted.
- Random out_ready and in_valid gaps on the SHA-256 vector -> identical word sequence versus the golden model; data_out stable while out_valid && !out_ready.
- abort asserted at round 20, then start with a new block -> no residual words; round restarts at 0; new block's W[0..15] emitted correctly.
- rst deasserted-then-asserted during LOAD after 7 words -> all outputs return to reset values immediately; a subsequent full block is correct.
- start pulsed during EXPAND and mode toggled during LOAD -> both ignored; word count and arithmetic follow the mode latched at the original start.
